rmii_tx_arb: RTL and testbench
==============================

RMII_TX_ARB -- requirements
Module: rmii_tx_arb

Interface
REQ-001 SHALL have parameter IFG_DIBITS, default 48, giving the inter-frame gap counter length in rmii_refclk cycles.
REQ-002 SHALL have parameter MIN_BYTES, default 60, giving the pad target in data bytes (used only under RMII_TX_ARB_PAD_EN).
REQ-003 SHALL have port rmii_refclk, input, 1 bit: the single clock, 50 MHz RMII reference clock; all logic is on its rising edge.
REQ-004 SHALL have port rst_l, input, 1 bit: reset, synchronous and active-low.
REQ-005 SHALL have port s_valid, input, 2 bits: byte valid per requester; bit n belongs to requester n.
REQ-006 SHALL have port s_data, input, 16 bits: byte per requester; [8n+7:8n] belongs to requester n.
REQ-007 SHALL have port s_last, input, 2 bits: the current byte is the final byte of the frame.
REQ-008 SHALL have port s_ready, output, 2 bits: the byte is accepted when s_valid[n] and s_ready[n] are both high.
REQ-009 SHALL have port rmii_txd, output, 2 bits: RMII transmit dibit.
REQ-010 SHALL have port rmii_tx_en, output, 1 bit: RMII transmit enable.
REQ-011 SHALL have port grant, output, 2 bits: one-hot owner of the current frame, zero when no frame is owned.
REQ-012 SHALL have port busy, output, 1 bit: high in every state except IDLE.
REQ-013 SHALL have port underrun, output, 1 bit: one-cycle pulse when a frame is aborted.

Function
REQ-014 SHALL use states IDLE, PRE, DATA, PAD, DRAIN and IFG.
REQ-015 IDLE: if any s_valid bit is high, SHALL latch a grant from the round-robin arbiter and enter PRE at the next edge.
REQ-016 Arbitration SHALL use 2-way round-robin: when both requesters are valid, the one not served last wins; after reset, requester 0 wins the first tie.
REQ-017 PRE SHALL drive rmii_tx_en=1 for 32 cycles: 31 dibits of 2'b01, then 2'b11 (7x 0x55 followed by SFD 0xD5).
REQ-018 s_ready[g] SHALL be high only for the granted requester g, on the last PRE cycle and on the 4th dibit cycle of each DATA byte whose byte was not marked last.
REQ-019 s_ready SHALL be decoded from registered state only and SHALL NOT depend on s_valid.
REQ-020 An accepted byte SHALL be loaded into the shift register and driven over the next 4 cycles, LSB dibit first ([1:0], [3:2], [5:4], [7:6]).
REQ-021 After the 4th dibit of a byte marked last, the next state SHALL be PAD (macro defined and byte count < MIN_BYTES) or IFG.
REQ-022 Underrun: when s_ready[g] is high and s_valid[g] is low, SHALL drop rmii_tx_en at the next edge, pulse underrun for one cycle, and enter DRAIN.
REQ-023 DRAIN SHALL hold s_ready[g]=1 and discard bytes until an accepted byte has s_last=1, then enter IFG.
REQ-024 IFG SHALL hold rmii_tx_en=0 and rmii_txd=00 for IFG_DIBITS cycles, then enter IDLE.
REQ-025 The minimum tx_en-low gap between frames SHALL be IFG_DIBITS+1 cycles (IFG cycles plus the IDLE arbitration cycle).
REQ-026 rmii_txd SHALL be 00 whenever rmii_tx_en=0.
REQ-027 grant SHALL hold from PRE through the end of DRAIN or the last data/pad dibit, and SHALL read zero in IFG and IDLE.
REQ-028 The byte counter SHALL be 11 bits and saturate at 2047.
REQ-029 A requester dropping s_valid while in IDLE before being granted SHALL cause no grant.

Reset
REQ-030 While rst_l=0 at a rising edge: state=IDLE; rmii_txd=00, rmii_tx_en=0, s_ready=00, grant=00, busy=0, underrun=0; round-robin pointer favours requester 0; all counters zero.
REQ-031 Reset asserted mid-frame SHALL take effect at that edge, truncating the frame without an underrun pulse and without an IFG.

Configuration
REQ-032 When macro RMII_TX_ARB_PAD_EN is defined, frames shorter than MIN_BYTES SHALL be extended in PAD with 0x00 bytes (4 dibits of 00, tx_en=1) up to MIN_BYTES total; s_ready SHALL stay low during PAD.
REQ-033 When RMII_TX_ARB_PAD_EN is not defined, the PAD state SHALL be absent and frames SHALL end at the byte marked last.

Structure
REQ-034 Package rmii_pkg SHALL hold: the state enum, PRE_DIBIT (2'b01), SFD_DIBIT (2'b11), PRE_DIBITS (32) and the default MIN_BYTES/IFG_DIBITS constants.
REQ-035 Sub-module rmii_rr_arb SHALL implement the 2-way round-robin arbiter (req, advance strobe, one-hot grant).

Verification
REQ-036 Single frame, requester 0, bytes 0x01 0x02 (last), pad off -> 31x01, 11, then dibits 01 00 00 00 10 00 00 00; tx_en high for 40 cycles.
REQ-037 Both requesters valid out of reset -> requester 0 frame first; requester 1 frame starts after exactly 49 cycles with tx_en low.
REQ-038 Requester 0 valid continuously for 3 frames while requester 1 is also valid -> grants alternate 0,1,0,1.
REQ-039 s_valid low on the 2nd s_ready cycle -> tx_en drops at the next edge, underrun pulses one cycle, bytes are drained until last, then 48 IFG cycles.
REQ-040 Pad on, 10-byte frame -> 50 zero bytes appended; tx_en high for 32+240 cycles.
REQ-041 rst_l=0 during DATA byte 5 -> at that edge tx_en=0, grant=00, busy=0; after release, next arbitration tie goes to requester 0.

Source files
------------

// File: rtl/rmii_pkg.sv
// Shared types and constants for the RMII transmit arbiter.
// The state list and RMII preamble/SFD constants live here so the top and the bench agree on them.
package rmii_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        PRE   = 3'd1,
        DATA  = 3'd2,
        PAD   = 3'd3,
        DRAIN = 3'd4,
        IFG   = 3'd5
    } state_t;

    localparam logic [1:0] PRE_DIBIT      = 2'b01;
    localparam logic [1:0] SFD_DIBIT      = 2'b11;
    localparam int         PRE_DIBITS     = 32;
    localparam int         DEF_MIN_BYTES  = 60;
    localparam int         DEF_IFG_DIBITS = 48;

    // A tie goes to the side the priority bit points at (0 -> requester 0).
    function automatic logic [1:0] rr_pick(input logic [1:0] req, input logic prio);
        if (req == 2'b11) begin
            return prio ? 2'b10 : 2'b01;
        end
        return req;
    endfunction

endpackage

// File: rtl/rmii_tx_arb_if.sv
// Per-requester byte stream handshake into the RMII transmit arbiter.
// The master drives valid/data/last, the slave (the arbiter) drives ready.
interface rmii_tx_arb_if;

    logic [1:0]  s_valid;
    logic [15:0] s_data;
    logic [1:0]  s_last;
    logic [1:0]  s_ready;

    modport master (
        output s_valid,
        output s_data,
        output s_last,
        input  s_ready
    );

    modport slave (
        input  s_valid,
        input  s_data,
        input  s_last,
        output s_ready
    );

endinterface

// File: rtl/rmii_rr_arb.sv
// Two-way round-robin arbiter: combinational one-hot grant, pointer moves on the advance strobe.
// After reset a tie is resolved in favour of requester 0.
module rmii_rr_arb
    import rmii_pkg::*;
(
    input  logic       clk,
    input  logic       rst_l,
    input  logic [1:0] i_req,
    input  logic       i_adv,
    output logic [1:0] o_gnt
);

    logic r_prio;

    assign o_gnt = rr_pick(i_req, r_prio);

    // Serving requester 0 hands the next tie to requester 1, and vice versa.
    always_ff @(posedge clk) begin
        if (!rst_l) begin
            r_prio <= 1'b0;
        end else if (i_adv && (|o_gnt)) begin
            r_prio <= o_gnt[0];
        end
    end

endmodule

// File: rtl/rmii_tx_arb.sv
// RMII transmit arbiter: picks one of two byte streams per frame, sends preamble/SFD, data dibits, then IFG.
// Define RMII_TX_ARB_PAD_EN to zero-pad short frames up to MIN_BYTES.
module rmii_tx_arb
    import rmii_pkg::*;
#(
    parameter int IFG_DIBITS = DEF_IFG_DIBITS,
    parameter int MIN_BYTES  = DEF_MIN_BYTES
) (
    input  logic         rmii_refclk,
    input  logic         rst_l,
    rmii_tx_arb_if.slave s_if,
    output logic [1:0]   rmii_txd,
    output logic         rmii_tx_en,
    output logic [1:0]   grant,
    output logic         busy,
    output logic         underrun
);

`ifdef RMII_TX_ARB_PAD_EN
    localparam bit PAD_ON = 1'b1;
`else
    localparam bit PAD_ON = 1'b0;
`endif
    localparam int CNT_MAX = (IFG_DIBITS > PRE_DIBITS) ? IFG_DIBITS : PRE_DIBITS;
    localparam int CW      = $clog2(CNT_MAX + 1);

    state_t      r_state;
    logic [CW-1:0] r_cnt;
    logic [1:0]  r_dib;
    logic [5:0]  r_shift;
    logic        r_last;
    logic [10:0] r_bytes;
    logic [1:0]  r_grant;
    logic [1:0]  r_txd;
    logic        r_tx_en;
    logic        r_underrun;

    logic [1:0]  w_arb_gnt;
    logic        w_arb_adv;
    logic        w_slot;
    logic        w_gv;
    logic        w_gl;
    logic [7:0]  w_gd;
    logic [10:0] w_bytes_inc;
    logic        w_short;
`ifdef RMII_TX_ARB_PAD_EN
    logic        w_pad_done;
`endif

    rmii_rr_arb u_arb (
        .clk   (rmii_refclk),
        .rst_l (rst_l),
        .i_req (s_if.s_valid),
        .i_adv (w_arb_adv),
        .o_gnt (w_arb_gnt)
    );

    // A byte slot is the SFD cycle or the final dibit of a non-last data byte.
    assign w_slot = ((r_state == PRE) && (r_cnt == CW'(PRE_DIBITS - 1)))
                 || ((r_state == DATA) && (r_dib == 2'd3) && !r_last);

    assign s_if.s_ready = (w_slot || (r_state == DRAIN)) ? r_grant : 2'b00;

    assign w_arb_adv   = (r_state == IDLE) && (|s_if.s_valid);
    assign w_gv        = |(s_if.s_valid & r_grant);
    assign w_gl        = |(s_if.s_last & r_grant);
    assign w_gd        = r_grant[1] ? s_if.s_data[15:8] : s_if.s_data[7:0];
    assign w_bytes_inc = (r_bytes == 11'h7FF) ? r_bytes : r_bytes + 11'd1;
    assign w_short     = PAD_ON && (r_bytes < 11'(MIN_BYTES));
`ifdef RMII_TX_ARB_PAD_EN
    assign w_pad_done  = (r_bytes >= 11'(MIN_BYTES - 1));
`endif

    assign rmii_txd   = r_txd;
    assign rmii_tx_en = r_tx_en;
    assign grant      = r_grant;
    assign busy       = (r_state != IDLE);
    assign underrun   = r_underrun;

    always_ff @(posedge rmii_refclk) begin
        if (!rst_l) begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            r_dib      <= 2'd0;
            r_shift    <= 6'd0;
            r_last     <= 1'b0;
            r_bytes    <= 11'd0;
            r_grant    <= 2'b00;
            r_txd      <= 2'b00;
            r_tx_en    <= 1'b0;
            r_underrun <= 1'b0;
        end else begin
            r_underrun <= 1'b0;
            if (w_slot) begin
                if (w_gv) begin
                    r_state <= DATA;
                    r_dib   <= 2'd0;
                    r_txd   <= w_gd[1:0];
                    r_shift <= w_gd[7:2];
                    r_last  <= w_gl;
                    r_bytes <= w_bytes_inc;
                end else begin
                    r_state    <= DRAIN;
                    r_tx_en    <= 1'b0;
                    r_txd      <= 2'b00;
                    r_underrun <= 1'b1;
                end
            end else begin
                case (r_state)
                    IDLE: begin
                        if (|s_if.s_valid) begin
                            r_state <= PRE;
                            r_grant <= w_arb_gnt;
                            r_cnt   <= '0;
                            r_bytes <= 11'd0;
                            r_tx_en <= 1'b1;
                            r_txd   <= PRE_DIBIT;
                        end
                    end
                    PRE: begin
                        r_cnt <= r_cnt + CW'(1);
                        if (r_cnt == CW'(PRE_DIBITS - 2)) begin
                            r_txd <= SFD_DIBIT;
                        end
                    end
                    DATA: begin
                        if (r_dib != 2'd3) begin
                            r_dib   <= r_dib + 2'd1;
                            r_txd   <= r_shift[1:0];
                            r_shift <= {2'b00, r_shift[5:2]};
                        end else if (w_short) begin
                            r_state <= PAD;
                            r_dib   <= 2'd0;
                            r_txd   <= 2'b00;
                        end else begin
                            r_state <= IFG;
                            r_cnt   <= '0;
                            r_tx_en <= 1'b0;
                            r_txd   <= 2'b00;
                            r_grant <= 2'b00;
                        end
                    end
`ifdef RMII_TX_ARB_PAD_EN
                    PAD: begin
                        r_dib <= r_dib + 2'd1;
                        if (r_dib == 2'd3) begin
                            r_bytes <= w_bytes_inc;
                            if (w_pad_done) begin
                                r_state <= IFG;
                                r_cnt   <= '0;
                                r_tx_en <= 1'b0;
                                r_grant <= 2'b00;
                            end
                        end
                    end
`endif
                    DRAIN: begin
                        if (w_gv && w_gl) begin
                            r_state <= IFG;
                            r_cnt   <= '0;
                            r_grant <= 2'b00;
                        end
                    end
                    IFG: begin
                        if (r_cnt == CW'(IFG_DIBITS - 1)) begin
                            r_state <= IDLE;
                        end else begin
                            r_cnt <= r_cnt + CW'(1);
                        end
                    end
                    default: begin
                        r_state <= IDLE;
                        r_tx_en <= 1'b0;
                        r_txd   <= 2'b00;
                        r_grant <= 2'b00;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_rmii_tx_arb.sv
// Directed bench for rmii_tx_arb: per-cycle output log plus hand-computed frame expectations.
// Covers single frame, round-robin, underrun/drain, mid-frame reset and (with the macro) padding.
module tb_rmii_tx_arb;

    localparam int LOGN = 1024;

    logic clk   = 1'b0;
    logic rst_l = 1'b0;
    always #10 clk = ~clk;

    rmii_tx_arb_if sif();
    logic [1:0] txd;
    logic [1:0] gnt;
    logic       tx_en;
    logic       busy;
    logic       und;

    rmii_tx_arb #(.IFG_DIBITS(48), .MIN_BYTES(60)) dut (
        .rmii_refclk (clk),
        .rst_l       (rst_l),
        .s_if        (sif),
        .rmii_txd    (txd),
        .rmii_tx_en  (tx_en),
        .grant       (gnt),
        .busy        (busy),
        .underrun    (und)
    );

    logic [8:0] q0[$];
    logic [8:0] q1[$];
    logic       log_en  [0:LOGN-1];
    logic [1:0] log_txd [0:LOGN-1];
    logic [1:0] log_gnt [0:LOGN-1];
    logic [1:0] log_rdy [0:LOGN-1];
    logic       log_busy[0:LOGN-1];
    logic       log_und [0:LOGN-1];
    int idx       = 0;
    int drop_n    = 0;
    int rdy_seen  = 0;
    int rst_at    = -1;
    int n_cmp     = 0;
    int n_bad     = 0;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_l = 1'b0;
        sif.s_valid = 2'b11;
        sif.s_data  = 16'hFFFF;
        sif.s_last  = 2'b00;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        check("reset_outputs", {tx_en, txd, sif.s_ready, gnt, busy, und}, 0);
        sif.s_valid = 2'b00;
        q0.delete();
        q1.delete();
    endtask

    task automatic cyc();
        logic [1:0] acc;
        @(negedge clk);
        rst_l = (idx == rst_at) ? 1'b0 : 1'b1;
        if (idx == rst_at) begin
            q0.delete();
            q1.delete();
        end
        if (idx < LOGN) begin
            log_en[idx]   = tx_en;
            log_txd[idx]  = txd;
            log_gnt[idx]  = gnt;
            log_rdy[idx]  = sif.s_ready;
            log_busy[idx] = busy;
            log_und[idx]  = und;
        end
        sif.s_valid = 2'b00;
        sif.s_data  = 16'h0000;
        sif.s_last  = 2'b00;
        if (q0.size() > 0) begin
            sif.s_valid[0]   = 1'b1;
            sif.s_data[7:0]  = q0[0][7:0];
            sif.s_last[0]    = q0[0][8];
        end
        if (q1.size() > 0) begin
            sif.s_valid[1]   = 1'b1;
            sif.s_data[15:8] = q1[0][7:0];
            sif.s_last[1]    = q1[0][8];
        end
        if (drop_n > 0 && sif.s_ready[0]) begin
            rdy_seen++;
            if (rdy_seen == drop_n) sif.s_valid[0] = 1'b0;
        end
        acc = sif.s_valid & sif.s_ready;
        @(posedge clk);
        if (rst_l) begin
            if (acc[0]) void'(q0.pop_front());
            if (acc[1]) void'(q1.pop_front());
        end
        idx++;
    endtask

    task automatic run(input int n);
        idx      = 0;
        rdy_seen = 0;
        repeat (n) cyc();
    endtask

    function automatic int first_en(input int from);
        for (int i = from; i < LOGN; i++) begin
            if (log_en[i]) return i;
        end
        return -1;
    endfunction

    function automatic int en_len(input int s);
        int n = 0;
        if (s < 0) return 0;
        for (int i = s; i < LOGN; i++) begin
            if (!log_en[i]) break;
            n++;
        end
        return n;
    endfunction

    function automatic logic [63:0] txd_word(input int s, input int n);
        logic [63:0] w = '0;
        for (int i = 0; i < n; i++) begin
            if (s + i >= 0 && s + i < LOGN) w = {w[61:0], log_txd[s + i]};
        end
        return w;
    endfunction

    function automatic logic [63:0] exp_bytes(input logic [7:0] b0, input logic [7:0] b1);
        logic [63:0] w  = '0;
        logic [15:0] bb = {b1, b0};
        for (int i = 0; i < 8; i++) w = {w[61:0], bb[2*i +: 2]};
        return w;
    endfunction

    function automatic logic [63:0] exp_pre();
        logic [63:0] w = '0;
        for (int i = 0; i < 31; i++) w = {w[61:0], 2'b01};
        return {w[61:0], 2'b11};
    endfunction

    initial begin
        int s, s2, s3, s4, bad, cnt;
        sif.s_valid = 2'b00;
        sif.s_data  = 16'h0000;
        sif.s_last  = 2'b00;

        // Single two-byte frame from requester 0
        do_reset();
        q0.push_back({1'b0, 8'h01});
        q0.push_back({1'b1, 8'h02});
        run(100);
        s = first_en(0);
        check("t1_start", s, 1);
        if (s < 0) s = 0;
        check("t1_len", en_len(s), 40);
        check("t1_pre", txd_word(s, 32), exp_pre());
        check("t1_data", txd_word(s + 32, 8), 64'h0000_0000_0000_4080);
        check("t1_grant", log_gnt[s], 2'b01);
        check("t1_ready", {log_rdy[s + 30], log_rdy[s + 31], log_rdy[s + 35], log_rdy[s + 39]}, 8'b00_01_01_00);
        check("t1_ifg", {log_en[s + 40], log_txd[s + 40], log_gnt[s + 40], log_busy[s + 40]}, 6'b0_00_00_1);
        check("t1_idle", {log_busy[s + 87], log_busy[s + 88]}, 2'b10);
        check("t1_q_empty", q0.size(), 0);

        // Both requesters valid: round-robin order and 49-cycle gap
        do_reset();
        q0.push_back({1'b0, 8'h10}); q0.push_back({1'b1, 8'h11});
        q0.push_back({1'b0, 8'h20}); q0.push_back({1'b1, 8'h21});
        q0.push_back({1'b0, 8'h30}); q0.push_back({1'b1, 8'h31});
        q1.push_back({1'b0, 8'hC0}); q1.push_back({1'b1, 8'hC1});
        q1.push_back({1'b0, 8'hD0}); q1.push_back({1'b1, 8'hD1});
        run(420);
        s = first_en(0);
        if (s < 0) s = 0;
        s2 = first_en(s + en_len(s));
        if (s2 < 0) s2 = 0;
        s3 = first_en(s2 + en_len(s2));
        if (s3 < 0) s3 = 0;
        s4 = first_en(s3 + en_len(s3));
        if (s4 < 0) s4 = 0;
        check("t2_gap", s2 - (s + 40), 49);
        check("t2_rr_order", {log_gnt[s], log_gnt[s2], log_gnt[s3], log_gnt[s4]}, 8'b01_10_01_10);
        check("t2_f2_data", txd_word(s2 + 32, 8), exp_bytes(8'hC0, 8'hC1));
        check("t2_f3_data", txd_word(s3 + 32, 8), exp_bytes(8'h20, 8'h21));
        bad = 0;
        for (int i = 0; i < 420; i++) begin
            if (!log_en[i] && log_txd[i] != 2'b00) bad++;
        end
        check("t2_txd_idle_zero", bad, 0);

        // Underrun on the second ready cycle, then drain to last
        do_reset();
        q0.push_back({1'b0, 8'hA1});
        q0.push_back({1'b0, 8'hB0});
        q0.push_back({1'b0, 8'hB1});
        q0.push_back({1'b1, 8'hB2});
        drop_n = 2;
        run(100);
        drop_n = 0;
        s = first_en(0);
        if (s < 0) s = 0;
        check("t3_len", en_len(s), 36);
        check("t3_underrun", {log_und[s + 35], log_und[s + 36], log_und[s + 37]}, 3'b010);
        cnt = 0;
        for (int i = 0; i < 100; i++) if (log_und[i]) cnt++;
        check("t3_pulses", cnt, 1);
        check("t3_drain_txd", log_txd[s + 36], 2'b00);
        check("t3_drain_grant", {log_gnt[s + 38], log_gnt[s + 39]}, 4'b01_00);
        check("t3_ifg_len", {log_busy[s + 86], log_busy[s + 87]}, 2'b10);
        check("t3_drained", q0.size(), 0);

        // Reset during data byte 5, then a tie must go to requester 0
        do_reset();
        for (int i = 0; i < 8; i++) q0.push_back({(i == 7), 8'(i + 8'h40)});
        rst_at = 50;
        run(60);
        rst_at = -1;
        check("t4_live", log_en[50], 1'b1);
        check("t4_cut", {log_en[51], log_gnt[51], log_busy[51], log_und[51]}, 0);
        bad = 0;
        for (int i = 51; i < 60; i++) if (log_en[i] || log_busy[i] || log_und[i]) bad++;
        check("t4_quiet", bad, 0);
        q0.push_back({1'b1, 8'h5A});
        q1.push_back({1'b1, 8'hA5});
        run(50);
        s = first_en(0);
        check("t4_restart", s, 1);
        if (s < 0) s = 0;
        check("t4_tie_r0", log_gnt[s], 2'b01);

        // Ten-byte frame: padded to 60 bytes only with the pad option
        do_reset();
        for (int i = 0; i < 10; i++) q0.push_back({(i == 9), 8'(i + 8'h90)});
        run(360);
        s = first_en(0);
        if (s < 0) s = 0;
`ifdef RMII_TX_ARB_PAD_EN
        check("t5_len", en_len(s), 272);
        bad = 0;
        for (int i = s + 72; i < s + 272; i++) if (log_txd[i] != 2'b00 || log_rdy[i] != 2'b00) bad++;
        check("t5_pad_zero", bad, 0);
        check("t5_pad_grant", {log_gnt[s + 271], log_gnt[s + 272]}, 4'b01_00);
`else
        check("t5_len", en_len(s), 72);
        check("t5_end_grant", {log_gnt[s + 71], log_gnt[s + 72]}, 4'b01_00);
`endif
        check("t5_first_byte", txd_word(s + 32, 8), exp_bytes(8'h90, 8'h91));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
